// File: rtl/fp_unit_mc_if.sv
// Handshake bundle for the multicycle FP unit: operand request channel
// (in_valid/in_ready) and result channel (out_valid/out_ready).
interface fp_unit_mc_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic         in_valid;
  logic         in_ready;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic [3:0]   flags;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, flags
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, flags
  );
endinterface

// File: rtl/fp_unit_mc.sv
// Multicycle IEEE-754 add/sub/mul unit with round-to-nearest-even.
// One operation in flight; states IDLE -> ALIGN -> EXEC -> NORM -> ROUND -> DONE.
// Working significand layout: {carry, hidden, fraction, G, R, S}.
module fp_unit_mc #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic        clk,
  input  logic        reset,
  fp_unit_mc_if.slave bus
);
  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int SW = MAN_W + 1;
  localparam int XW = MAN_W + 5;
  localparam int EW = EXP_W + 2;
  localparam int PW = 2 * SW;

  localparam logic signed [EW-1:0] EXP_ZERO = '0;
  localparam logic signed [EW-1:0] EXP_ONE  = EW'(1);
  localparam logic signed [EW-1:0] BIAS     = EW'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [EW-1:0] EXP_MAX  = EW'((1 << EXP_W) - 1);
  localparam logic [EXP_W-1:0]     EXP_ONES = '1;
  localparam logic [W-1:0]         QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, ALIGN, EXEC, NORM, ROUND, DONE} state_t;

  state_t               state_q;
  logic [W-1:0]         aOp_q, bOp_q;
  logic [1:0]           op_q;
  logic [XW-1:0]        sigX_q, sigY_q, man_q;
  logic                 signX_q, signY_q, sign_q;
  logic signed [EW-1:0] exp_q;
  logic [W-1:0]         result_q;
  logic [3:0]           flags_q;
  logic                 outValid_q, inReady_q;

  assign bus.in_ready  = inReady_q;
  assign bus.out_valid = outValid_q;
  assign bus.result    = result_q;
  assign bus.flags     = flags_q;

  // Operand unpacking and classification of the latched operands
  logic             sa, sb, sbEff, isMul, isSub;
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;
  logic             zeroA, zeroB, infA, infB, nanA, nanB;
  logic [SW-1:0]    sigA, sigB;
  logic [XW-1:0]    extA, extB;

  assign {sa, ea, fa} = aOp_q;
  assign {sb, eb, fb} = bOp_q;
  assign isMul = (op_q == 2'b10);
  assign isSub = (op_q == 2'b01);
  assign sbEff = sb ^ isSub;
  assign zeroA = (ea == '0);
  assign zeroB = (eb == '0);
  assign infA  = (ea == EXP_ONES) && (fa == '0);
  assign infB  = (eb == EXP_ONES) && (fb == '0);
  assign nanA  = (ea == EXP_ONES) && (fa != '0);
  assign nanB  = (eb == EXP_ONES) && (fb != '0);
  assign sigA  = {~zeroA, fa};
  assign sigB  = {~zeroB, fb};
  assign extA  = {1'b0, sigA, 3'b000};
  assign extB  = {1'b0, sigB, 3'b000};

  // Alignment: shift the smaller-exponent significand right, folding lost bits into sticky
  logic                 swap;
  logic [EXP_W-1:0]     expDiff;
  logic [XW-1:0]        bigSig, smallSig, lostMask, shifted_d;
  logic signed [EW-1:0] alignExp_d, mulExp_d;

  always_comb begin
    swap       = (eb > ea);
    bigSig     = swap ? extB : extA;
    smallSig   = swap ? extA : extB;
    expDiff    = swap ? (eb - ea) : (ea - eb);
    alignExp_d = $signed({2'b00, (swap ? eb : ea)});
    mulExp_d   = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS;
    lostMask   = '0;
    if (int'(expDiff) > MAN_W + 3) begin
      shifted_d = {{(XW-1){1'b0}}, |smallSig};
    end else begin
      lostMask  = ~({XW{1'b1}} << expDiff);
      shifted_d = (smallSig >> expDiff) | {{(XW-1){1'b0}}, |(smallSig & lostMask)};
    end
  end

  // Special-operand resolution (NaN, infinity, zero) that bypasses the datapath
  logic         special_d, specialInv_d;
  logic [W-1:0] specialRes_d;

  always_comb begin
    special_d    = 1'b1;
    specialInv_d = 1'b0;
    specialRes_d = '0;
    if (isMul) begin
      if (nanA || nanB || (infA && zeroB) || (zeroA && infB)) begin
        specialRes_d = QNAN;
        specialInv_d = 1'b1;
      end else if (infA || infB) begin
        specialRes_d = {sa ^ sb, EXP_ONES, {MAN_W{1'b0}}};
      end else if (zeroA || zeroB) begin
        specialRes_d = {sa ^ sb, {(W-1){1'b0}}};
      end else begin
        special_d = 1'b0;
      end
    end else begin
      if (nanA || nanB || (infA && infB && (sa != sbEff))) begin
        specialRes_d = QNAN;
        specialInv_d = 1'b1;
      end else if (infA) begin
        specialRes_d = {sa, EXP_ONES, {MAN_W{1'b0}}};
      end else if (infB) begin
        specialRes_d = {sbEff, EXP_ONES, {MAN_W{1'b0}}};
      end else if (zeroA && zeroB) begin
        specialRes_d = {sa & sbEff, {(W-1){1'b0}}};
      end else if (zeroA) begin
        specialRes_d = {sbEff, eb, fb};
      end else if (zeroB) begin
        specialRes_d = aOp_q;
      end else begin
        special_d = 1'b0;
      end
    end
  end

  // Execute: signed-magnitude add/sub of aligned significands, or full product with G/R/S fold
  logic [PW-1:0] product;
  logic [XW-1:0] mulExt, execMan_d;
  logic          execSign_d, execZero_d;

  always_comb begin
    product    = PW'(sigX_q[SW-1:0]) * PW'(sigY_q[SW-1:0]);
    mulExt     = {product[PW-1:MAN_W-1], product[MAN_W-2], |product[MAN_W-3:0]};
    execMan_d  = mulExt;
    execSign_d = sign_q;
    execZero_d = 1'b0;
    if (!isMul) begin
      if (signX_q == signY_q) begin
        execMan_d  = sigX_q + sigY_q;
        execSign_d = signX_q;
      end else if (sigX_q >= sigY_q) begin
        execMan_d  = sigX_q - sigY_q;
        execSign_d = signX_q;
      end else begin
        execMan_d  = sigY_q - sigX_q;
        execSign_d = signY_q;
      end
      execZero_d = (execMan_d == '0);
    end
  end

  // Round-to-nearest-even with renormalisation and overflow/underflow packing
  logic                 roundUp, inexact, hidden;
  logic [MAN_W+1:0]     rounded;
  logic [MAN_W-1:0]     frac;
  logic signed [EW-1:0] expR;
  logic [W-1:0]         roundRes_d;
  logic [3:0]           roundFlags_d;

  always_comb begin
    roundUp = man_q[2] & (man_q[1] | man_q[0] | man_q[3]);
    inexact = man_q[2] | man_q[1] | man_q[0];
    rounded = man_q[XW-1:3] + {{(MAN_W+1){1'b0}}, roundUp};
    if (rounded[MAN_W+1]) begin
      frac   = rounded[MAN_W:1];
      hidden = 1'b1;
      expR   = exp_q + EXP_ONE;
    end else begin
      frac   = rounded[MAN_W-1:0];
      hidden = rounded[MAN_W];
      expR   = exp_q;
    end
    roundRes_d   = {sign_q, expR[EXP_W-1:0], frac};
    roundFlags_d = {3'b000, inexact};
    if (expR >= EXP_MAX) begin
      roundRes_d   = {sign_q, EXP_ONES, {MAN_W{1'b0}}};
      roundFlags_d = 4'b0101;
    end else if ((expR <= EXP_ZERO) || !hidden) begin
      roundRes_d   = {sign_q, {(W-1){1'b0}}};
      roundFlags_d = 4'b0011;
    end
  end

  // Control FSM and all datapath registers, with registered handshake outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      outValid_q <= 1'b0;
      inReady_q  <= 1'b0;
      result_q   <= '0;
      flags_q    <= '0;
      aOp_q      <= '0;
      bOp_q      <= '0;
      op_q       <= '0;
      sigX_q     <= '0;
      sigY_q     <= '0;
      man_q      <= '0;
      signX_q    <= 1'b0;
      signY_q    <= 1'b0;
      sign_q     <= 1'b0;
      exp_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          inReady_q <= 1'b1;
          if (bus.in_valid && inReady_q) begin
            aOp_q     <= bus.a;
            bOp_q     <= bus.b;
            op_q      <= bus.op;
            inReady_q <= 1'b0;
            state_q   <= ALIGN;
          end
        end
        ALIGN: begin
          if (special_d) begin
            result_q   <= specialRes_d;
            flags_q    <= {specialInv_d, 3'b000};
            outValid_q <= 1'b1;
            state_q    <= DONE;
          end else if (isMul) begin
            sigX_q  <= XW'(sigA);
            sigY_q  <= XW'(sigB);
            exp_q   <= mulExp_d;
            sign_q  <= sa ^ sb;
            state_q <= EXEC;
          end else begin
            sigX_q  <= bigSig;
            sigY_q  <= shifted_d;
            signX_q <= swap ? sbEff : sa;
            signY_q <= swap ? sa : sbEff;
            exp_q   <= alignExp_d;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          if (execZero_d) begin
            result_q   <= '0;
            flags_q    <= '0;
            outValid_q <= 1'b1;
            state_q    <= DONE;
          end else begin
            man_q   <= execMan_d;
            sign_q  <= execSign_d;
            state_q <= NORM;
          end
        end
        NORM: begin
          if (man_q[XW-1]) begin
            man_q <= {1'b0, man_q[XW-1:2], man_q[1] | man_q[0]};
            exp_q <= exp_q + EXP_ONE;
          end else if (!man_q[XW-2] && (exp_q > EXP_ONE)) begin
            man_q <= {man_q[XW-2:0], 1'b0};
            exp_q <= exp_q - EXP_ONE;
          end else begin
            state_q <= ROUND;
          end
        end
        ROUND: begin
          result_q   <= roundRes_d;
          flags_q    <= roundFlags_d;
          outValid_q <= 1'b1;
          state_q    <= DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            outValid_q <= 1'b0;
            inReady_q  <= 1'b1;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/fp_unit_mc.md
Name: fp_unit_mc

Overview:
- Parametrised multicycle IEEE-754 binary floating-point unit supporting add, subtract and multiply. Default format is binary32.
- Sits beside the integer ALU in the multicycle core and handles one operation at a time.
- Uses a valid/ready handshake on both input and output.
- Adds to the single-cycle FP datapath:
  - subtraction and signed addition;
  - round-to-nearest-even with guard/round/sticky bits;
  - iterative normalisation, including massive cancellation;
  - handling of zero, infinity and NaN;
  - exception flags.

Parameters:
- EXP_W, 8: exponent field width. Bias = 2^(EXP_W-1)-1.
- MAN_W, 23: stored fraction width. Hidden bit is implicit.
- Derived (not overridable): W = 1+EXP_W+MAN_W.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset. Asserted when 0 and sampled on the clk rising edge.
- in_valid  in  1  operands and op are presented.
- in_ready  out  1  unit can accept; high only in IDLE.
- op  in  2  2'b00 add, 2'b01 sub (a-b), 2'b10 mul, 2'b11 reserved (treated as add).
- a  in  W  operand A.
- b  in  W  operand B.
- out_valid  out  1  result and flags valid.
- out_ready  in  1  consumer accepts the result.
- result  out  W  packed result.
- flags  out  4  {invalid, overflow, underflow, inexact}.

Behaviour:
- Reset (reset==0 at an edge):
  - state=IDLE, out_valid=0, result=0, flags=0.
  - in_ready=0 during the reset cycle, 1 on the following cycle.
  - Reset mid-operation aborts it silently; no result is produced.
- States: IDLE, ALIGN, EXEC, NORM, ROUND, DONE.
- IDLE: in_ready=1. An edge with in_valid&&in_ready latches a, b and op, then goes to ALIGN.
- ALIGN: unpack sign, exponent and 24-bit significand (hidden bit=1 if exponent!=0). Denormal inputs are flushed to signed zero.
  - Specials resolve here and go straight to DONE:
    - any NaN, inf-inf (effective subtract), or 0*inf → 0x7FC00000 scaled to format (exp all 1s, fraction MSB 1), invalid=1;
    - inf operand otherwise → correctly signed inf;
    - zero operand:
      - add/sub → other operand (sign of b inverted for sub);
      - x+(-x) and 0+(-0) → +0;
      - mul → signed zero.
  - Otherwise, for add/sub, shift the smaller-exponent significand right by the exponent difference. Shifted-out bits collapse into sticky; a difference > MAN_W+3 leaves only sticky. Go to EXEC.
- EXEC:
  - Add/sub: effective add or subtract of the extended significands (hidden+MAN_W+G+R+S, plus 1 carry bit). On subtraction, the larger magnitude minus the smaller sets the result sign.
  - Mul: full (MAN_W+1)x(MAN_W+1) product; result exponent = ea+eb-bias; sign = sa^sb. Low product bits fold into G/R/S.
  - Exact-zero add/sub result → +0 in DONE. Otherwise go to NORM.
- NORM, one action per cycle:
  - carry bit set: shift right 1 (LSB ORed into sticky), exp+1;
  - else hidden position 0 and exp>1: shift left 1, exp-1;
  - else go to ROUND.
  - Left shifts stop at exp==1 (result becomes denormal-range and is flushed in ROUND).
- ROUND:
  - RNE: increment when G&&(R|S|LSB). Mantissa overflow from rounding renormalises in the same cycle (exp+1).
  - inexact = G|R|S.
  - exp >= 2^EXP_W-1 → signed inf, overflow=1, inexact=1.
  - exp <= 0 or hidden bit 0 → signed zero, underflow=1, inexact=1.
  - Then go to DONE.
- DONE: out_valid=1. result and flags are stable while out_valid && !out_ready. An edge with out_valid&&out_ready goes to IDLE, and out_valid drops the next cycle. in_valid is ignored outside IDLE.
- Latency is measured from the accept edge to the edge that raises out_valid:
  - 4 for a normal result with no normalisation shift;
  - +1 per NORM shift;
  - 1 for specials and zero operands.
- No back-to-back accept: in_ready is 0 in the DONE cycle. Reserved op behaves exactly as add.

Test Plan:
- add 0x3FC00000+0x40200000 (1.5+2.5) → result 0x40800000, flags 0, out_valid 5 edges after accept (one carry right-shift).
- sub 0x3F800000-0x3F7FFFFF → result 0x33800000, flags 0, latency 4+24=28 edges; then sub 0x3F800000-0x3F800000 → 0x00000000.
- mul 0x3FC00000*0x3FC00000 (1.5*1.5) → 0x40100000, latency 5; mul 0x7F7FFFFF*0x40000000 → 0x7F800000, flags 4'b0101.
- Specials: sub 0x7F800000-0x7F800000 → 0x7FC00000 flags 4'b1000 latency 1; mul 0x00000000*0xC0000000 → 0x80000000 flags 0.
- Rounding: add 0x3F800000+0x33800000 (1+2^-24, tie, LSB 0) → 0x3F800000 inexact=1; add 0x3F800001+0x33800000 → 0x3F800002 inexact=1.
- Handshake/reset: hold out_ready=0 for 10 cycles → result stable, in_ready=0; pulse reset=0 during NORM of the cancellation case → out_valid never rises, in_ready=1 one cycle after reset released; parameter run EXP_W=5,MAN_W=10: 0x3C00+0x3C00 → 0x4000.
